uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//   Standalone UART receiver, 8N1 by default; receiving end for the uart_controller TX path.
//   Samples the asynchronous serial line at RX_OVERSAMPLE x baud. Majority-votes each bit at mid-bit.
//   Rejects glitch start bits. Flags framing errors and, optionally, parity errors.
//   Sits between the pad-level RX pin and the byte-oriented host logic.
// PARAMETERS
//   CLOCK_RATE     25000000  system clock frequency, Hz
//   BAUD_RATE      115200    line rate, bit/s
//   RX_OVERSAMPLE  16        sample ticks per bit; even, >=8
//   PARITY_ODD     0         parity sense when UART_RX_PARITY_EN is defined: 0=even, 1=odd
// PORTS
//   clk             in   1  system clock, all logic on rising edge
//   reset_n         in   1  asynchronous, active-low reset
//   i_Rx_Data       in   1  serial line; asynchronous to clk; idles high
//   o_Rx_Byte       out  8  last good byte; held until the next good byte
//   o_Rx_Done       out  1  1-clk pulse, o_Rx_Byte valid/updated this cycle
//   o_Rx_Frame_Err  out  1  1-clk pulse, stop bit sampled low
//   o_Rx_Parity_Err out  1  1-clk pulse, parity mismatch (constant 0 without UART_RX_PARITY_EN)
//   o_Rx_Busy       out  1  high from start-edge detect until return to IDLE
// BEHAVIOUR
// - Reset values: o_Rx_Byte=8'h00; o_Rx_Done, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Busy = 0.
// - Reset also clears: state=IDLE, all counters=0, synchronizer flops=1.
// - Line sync: 2-flop synchronizer plus a 3rd flop for edge detect. Edge latency is 2 clk.
// - Tick: TICK_DIV = (CLOCK_RATE + BAUD_RATE*RX_OVERSAMPLE/2) / (BAUD_RATE*RX_OVERSAMPLE), i.e. rounded.
//   With the defaults TICK_DIV=14, so one bit = 224 clk.
//   The tick counter is zeroed on the start edge so sampling is phase-aligned to each frame.
// - Sample: bit value = majority of synchronized line at ticks M-1, M, M+1, where M = RX_OVERSAMPLE/2.
//   The bit decision is taken at tick M+1. The tick index wraps RX_OVERSAMPLE-1 -> 0.
// - FSM:
//   IDLE   : on synced falling edge -> START, o_Rx_Busy<=1.
//   START  : at mid-bit, vote=0 -> DATA, bit index=0.
//            Vote=1 -> IDLE (glitch rejected, no output pulses).
//   DATA   : shift voted bit into MSB of shift reg, LSB first. After bit index 7:
//            -> PARITY if UART_RX_PARITY_EN is defined, else -> STOP.
//   PARITY : vote compared with XOR(data)^PARITY_ODD. Mismatch latched, pulse issued in STOP.
//   STOP   : at mid-bit, vote=1 and no parity error -> o_Rx_Byte<=shift, o_Rx_Done=1 for 1 clk, -> IDLE.
//            vote=1 with parity error -> o_Rx_Parity_Err=1 for 1 clk, byte not updated, -> IDLE.
//            vote=0 -> o_Rx_Frame_Err=1 for 1 clk, byte not updated, -> BREAK.
//   BREAK  : wait for synced line=1 -> IDLE. Covers a held-low line; no repeated error pulses.
// - o_Rx_Busy falls on the cycle the FSM enters IDLE.
// - Latency: o_Rx_Done rises at start-edge + 2 clk sync + (9 or 10 bits + M+1 ticks) x TICK_DIV.
// - A new start edge is accepted from the first IDLE cycle, so back-to-back frames are allowed.
//   No idle gap is required beyond the stop bit.
// - Done and error pulses are mutually exclusive per frame.
// - Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded.
// - A line already low at reset release is seen as a start edge, because the sync flops reset to 1.
//   Its garbage frame ends in a frame error or a glitch reject, never in a false o_Rx_Done with stop=0.
// - Tolerated baud mismatch: at least +/-3% total (e.g. 217-clk bits against 224-clk sampling).
// CONFIGURATION
//   UART_RX_PARITY_EN defined: frame = start, 8 data, 1 parity, 1 stop. PARITY state is present.
//     o_Rx_Parity_Err is live.
//   UART_RX_PARITY_EN undefined: 8N1 frame. PARITY state is not generated.
//     o_Rx_Parity_Err is tied to 0.
// TESTING
//   T1: drive 8'h55 8N1 at 217 clk/bit (25 MHz, 115200 baud).
//       -> exactly one o_Rx_Done; o_Rx_Byte=8'h55; no error pulses.
//   T2: back-to-back frames 01,10,22,32,55,AA,AB,88, no idle gap.
//       -> 8 o_Rx_Done pulses, bytes received in order.
//   T3: line low for 3 clk, then high.
//       -> o_Rx_Busy pulses briefly; no Done or Err; o_Rx_Byte unchanged.
//   T4: after receiving 8'h55, send 8'hA5 with the stop bit low, then hold the line low for 3 bit times.
//       -> one o_Rx_Frame_Err; o_Rx_Byte stays 8'h55.
//       -> the next frame 8'h3C is received correctly after the line returns high.
//   T5: assert reset_n=0 during data bit 4 of 8'hF0, release, then send 8'h0F.
//       -> all outputs go to 0 during reset; one o_Rx_Done with 8'h0F.
//   T6 (UART_RX_PARITY_EN, PARITY_ODD=0): send 8'h33 with parity=1.
//       -> o_Rx_Parity_Err pulse, no Done.
//       -> then send 8'h33 with parity=0 -> o_Rx_Done, byte 8'h33.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 8N1 by default, one parity bit when UART_RX_PARITY_EN is defined.
// Each bit is a 3-sample majority vote around mid-bit; glitch starts are rejected and bad stop bits flagged.
module uart_rx_oversampled #(
    parameter int CLOCK_RATE    = 25000000,
    parameter int BAUD_RATE     = 115200,
    parameter int RX_OVERSAMPLE = 16,
    parameter int PARITY_ODD    = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_Rx_Data,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Done,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Parity_Err,
    output logic       o_Rx_Busy
);

    localparam int TICK_DIV = (CLOCK_RATE + BAUD_RATE * RX_OVERSAMPLE / 2) / (BAUD_RATE * RX_OVERSAMPLE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W    = $clog2(RX_OVERSAMPLE);
    localparam int MID      = RX_OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(RX_OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_EARLY = IDX_W'(MID - 1);
    localparam logic [IDX_W-1:0] IDX_MID   = IDX_W'(MID);
    localparam logic [IDX_W-1:0] IDX_LATE  = IDX_W'(MID + 1);

    if (RX_OVERSAMPLE < 8 || (RX_OVERSAMPLE % 2) != 0 || TICK_DIV < 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_oversampled: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
    localparam logic   PAR_SENSE  = PARITY_ODD[0];
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state, state_next;
    logic             sync_1, sync_2, sync_3;
    logic             line, fall_edge;
    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] tick_idx, next_idx;
    logic             tick, sample_now, decide;
    logic [1:0]       vote_sh;
    logic             vote;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift_reg;
    logic             shift_en, load_byte, done_next, ferr_next;

    // Line synchronizer; the third flop only exists to spot the falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            sync_3 <= 1'b1;
        end else begin
            sync_1 <= i_Rx_Data;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign line      = sync_2;
    assign fall_edge = sync_3 & ~sync_2;

    assign tick       = (div_cnt == DIV_LAST);
    assign next_idx   = (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
    assign sample_now = tick && (next_idx == IDX_EARLY || next_idx == IDX_MID || next_idx == IDX_LATE);
    assign decide     = tick && (next_idx == IDX_LATE);
    assign vote       = majority3(vote_sh[1], vote_sh[0], line);

    // Tick timebase is held at zero while idle so every frame starts phase-aligned to its start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            tick_idx <= '0;
            vote_sh  <= 2'b11;
        end else begin
            if (state == S_IDLE) begin
                div_cnt  <= '0;
                tick_idx <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_idx <= next_idx;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (sample_now) begin
                vote_sh <= {vote_sh[0], line};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err, parity_err_next, parity_pulse;
`endif

    always_comb begin
        state_next = state;
        bit_next   = bit_idx;
        shift_en   = 1'b0;
        load_byte  = 1'b0;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_next = parity_err;
        parity_pulse    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (fall_edge) begin
                    state_next = S_START;
`ifdef UART_RX_PARITY_EN
                    parity_err_next = 1'b0;
`endif
                end
            end
            S_START: begin
                if (decide) begin
                    state_next = vote ? S_IDLE : S_DATA;
                    bit_next   = 3'd0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    bit_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = AFTER_DATA;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (decide) begin
                    parity_err_next = (vote != ((^shift_reg) ^ PAR_SENSE));
                    state_next      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (decide) begin
                    if (!vote) begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end else begin
                        state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_err) begin
                            parity_pulse = 1'b1;
                        end else begin
                            load_byte = 1'b1;
                            done_next = 1'b1;
                        end
`else
                        load_byte = 1'b1;
                        done_next = 1'b1;
`endif
                    end
                end
            end
            S_BREAK: begin
                if (line) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            bit_idx        <= 3'd0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Done      <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Busy      <= 1'b0;
        end else begin
            state          <= state_next;
            bit_idx        <= bit_next;
            o_Rx_Done      <= done_next;
            o_Rx_Frame_Err <= ferr_next;
            o_Rx_Busy      <= (state_next != S_IDLE);
            if (load_byte) begin
                o_Rx_Byte <= shift_reg;
            end
        end
    end

    // Data bits arrive LSB first, so each new bit enters at the top and the byte settles after eight shifts.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_reg <= {vote, shift_reg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err      <= 1'b0;
            o_Rx_Parity_Err <= 1'b0;
        end else begin
            parity_err      <= parity_err_next;
            o_Rx_Parity_Err <= parity_pulse;
        end
    end
`else
    assign o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: frame table with a pulse scoreboard, plus hand-written corner sequences.
module tb_uart_rx_oversampled;

    localparam int BIT_CLK = 217;
    localparam int K_DONE  = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] rx_byte;
    logic       done, ferr, perr, busy;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         bit_clk;
        int         exp_kind;
        logic [7:0] exp_byte;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[12];
    int   total = 0;
    int   bad = 0;
    bit   busy_seen = 1'b0;
    int   got_kind;
    exp_t e_got;

    always #5 clk = ~clk;

    uart_rx_oversampled dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_Rx_Data      (rx_line),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Done      (done),
        .o_Rx_Frame_Err (ferr),
        .o_Rx_Parity_Err(perr),
        .o_Rx_Busy      (busy)
    );

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (done || ferr || perr) begin
            got_kind = done ? K_DONE : (ferr ? K_FERR : K_PERR);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse got kind=%0d byte=%02h required no pulse", got_kind, rx_byte);
            end else begin
                e_got = exp_q.pop_front();
                if ((int'(done) + int'(ferr) + int'(perr)) != 1 || got_kind != e_got.kind ||
                    (got_kind == K_DONE && rx_byte !== e_got.data)) begin
                    bad++;
                    $display("FAIL pulse_match got kind=%0d byte=%02h (d%0d f%0d p%0d) required kind=%0d byte=%02h",
                             got_kind, rx_byte, done, ferr, perr, e_got.kind, e_got.data);
                end
            end
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog got timeout required test end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bclk, input logic par_bit);
        rx_line = 1'b0;
        hold(bclk);
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            hold(bclk);
        end
        if (HAS_PAR) begin
            rx_line = par_bit;
            hold(bclk);
        end
        rx_line = stop_bit;
        hold(bclk);
    endtask

    task automatic expect_pulse(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{8'h55, 1'b1, BIT_CLK, K_DONE, 8'h55};
        vecs[1]  = '{8'h01, 1'b1, BIT_CLK, K_DONE, 8'h01};
        vecs[2]  = '{8'h10, 1'b1, BIT_CLK, K_DONE, 8'h10};
        vecs[3]  = '{8'h22, 1'b1, BIT_CLK, K_DONE, 8'h22};
        vecs[4]  = '{8'h32, 1'b1, BIT_CLK, K_DONE, 8'h32};
        vecs[5]  = '{8'h55, 1'b1, BIT_CLK, K_DONE, 8'h55};
        vecs[6]  = '{8'hAA, 1'b1, BIT_CLK, K_DONE, 8'hAA};
        vecs[7]  = '{8'hAB, 1'b1, BIT_CLK, K_DONE, 8'hAB};
        vecs[8]  = '{8'h88, 1'b1, BIT_CLK, K_DONE, 8'h88};
        vecs[9]  = '{8'h00, 1'b1, 231,     K_DONE, 8'h00};
        vecs[10] = '{8'hFF, 1'b1, 224,     K_DONE, 8'hFF};
        vecs[11] = '{8'h81, 1'b1, 231,     K_DONE, 8'h81};

        // Reset state
        hold(5);
        check("reset_byte", rx_byte, 8'h00);
        check("reset_done", done, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        check("reset_perr", perr, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset_n = 1'b1;
        hold(20);

        // T1/T2 plus baud-skew frames, back to back with no idle gap
        for (int i = 0; i < 12; i++) begin
            expect_pulse(vecs[i].exp_kind, vecs[i].exp_byte);
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].bit_clk, ^vecs[i].data);
        end
        wait_drain("table_drain", 4000);
        hold(50);
        check("table_last_byte", rx_byte, 8'h81);
        check("table_idle_busy", busy, 1'b0);

        // T3: short glitch
        busy_seen = 1'b0;
        rx_line = 1'b0;
        hold(3);
        rx_line = 1'b1;
        hold(400);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_byte_kept", rx_byte, 8'h81);

        // T4: framing error followed by held-low line
        expect_pulse(K_DONE, 8'h55);
        send_frame(8'h55, 1'b1, BIT_CLK, ^8'h55);
        expect_pulse(K_FERR, 8'h00);
        send_frame(8'hA5, 1'b0, BIT_CLK, ^8'hA5);
        hold(3 * BIT_CLK);
        wait_drain("ferr_drain", 10);
        check("ferr_byte_kept", rx_byte, 8'h55);
        check("break_busy", busy, 1'b1);
        rx_line = 1'b1;
        hold(2 * BIT_CLK);
        check("break_exit_busy", busy, 1'b0);
        expect_pulse(K_DONE, 8'h3C);
        send_frame(8'h3C, 1'b1, BIT_CLK, ^8'h3C);
        wait_drain("after_break_drain", 4000);
        check("after_break_byte", rx_byte, 8'h3C);

        // T5: reset during data bit 4 of 8'hF0
        rx_line = 1'b0;
        hold(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx_line = 1'b0;
            hold(BIT_CLK);
        end
        rx_line = 1'b1;
        hold(100);
        check("midframe_busy", busy, 1'b1);
        reset_n = 1'b0;
        hold(2);
        check("midreset_byte", rx_byte, 8'h00);
        check("midreset_done", done, 1'b0);
        check("midreset_ferr", ferr, 1'b0);
        check("midreset_perr", perr, 1'b0);
        check("midreset_busy", busy, 1'b0);
        hold(20);
        reset_n = 1'b1;
        hold(500);
        expect_pulse(K_DONE, 8'h0F);
        send_frame(8'h0F, 1'b1, BIT_CLK, ^8'h0F);
        wait_drain("post_reset_drain", 4000);
        check("post_reset_byte", rx_byte, 8'h0F);

        // Line already low when reset releases: garbage frame must end in a frame error
        reset_n = 1'b0;
        rx_line = 1'b0;
        hold(5);
        expect_pulse(K_FERR, 8'h00);
        reset_n = 1'b1;
        hold(13 * BIT_CLK);
        wait_drain("low_reset_drain", 10);
        check("low_reset_byte", rx_byte, 8'h00);
        check("low_reset_busy", busy, 1'b1);
        rx_line = 1'b1;
        hold(300);
        check("low_reset_idle", busy, 1'b0);
        expect_pulse(K_DONE, 8'h5A);
        send_frame(8'h5A, 1'b1, BIT_CLK, ^8'h5A);
        wait_drain("low_reset_next_drain", 4000);
        check("low_reset_next_byte", rx_byte, 8'h5A);

`ifdef UART_RX_PARITY_EN
        // T6: parity mismatch, then the same byte with correct parity
        expect_pulse(K_PERR, 8'h00);
        send_frame(8'h33, 1'b1, BIT_CLK, 1'b1);
        wait_drain("perr_drain", 4000);
        check("perr_byte_kept", rx_byte, 8'h5A);
        expect_pulse(K_DONE, 8'h33);
        send_frame(8'h33, 1'b1, BIT_CLK, 1'b0);
        wait_drain("par_ok_drain", 4000);
        check("par_ok_byte", rx_byte, 8'h33);
`endif

        hold(100);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
